gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised up/down counter that keeps a binary count and a registered Gray-coded copy of it.
- It generalises the team's fixed 3-bit binary-to-Gray datapath (x=a, y=a^b, z=b^c) to WIDTH bits.
- It adds state, enable, direction, parallel load of a Gray value, and a wrap flag.
- Used as a pointer source for clock-crossing FIFOs and position encoders elsewhere in the design.

Parameters:
- WIDTH, 3, number of count bits (legal range 2..32).
- RESET_VAL, 0, binary count value loaded at reset (must be < 2**WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  count enable; advance one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_gray  input  WIDTH  Gray-coded value to load.
- bin_out  output  WIDTH  current count, binary, registered.
- gray_out  output  WIDTH  current count, Gray, registered.
- wrap  output  1  one-cycle pulse marking a wrap-around step.

Behaviour:
- All state updates on the rising clk edge. Reset is synchronous, active-low, on one clock; no asynchronous paths.
- Reset values:
  - bin_out = RESET_VAL.
  - gray_out = RESET_VAL ^ (RESET_VAL >> 1).
  - wrap = 0.
- Priority per edge: rst_n low > load > en > hold.
- Load:
  - bin_out <= gray2bin(load_gray), with bin[i] = XOR of load_gray[WIDTH-1:i].
  - gray_out <= load_gray.
  - wrap <= 0.
  - en and up are ignored in a load cycle.
- Count (en=1, load=0):
  - up=1: bin_out <= bin_out + 1 mod 2**WIDTH.
  - up=0: bin_out <= bin_out - 1 mod 2**WIDTH.
  - gray_out <= next_bin ^ (next_bin >> 1).
- Hold (en=0, load=0): all registers keep their value; wrap <= 0.
- Latency: one cycle from en/load sampled to the new bin_out/gray_out. bin_out and gray_out always change on the same edge.
- Gray invariant: gray_out == bin_out ^ (bin_out >> 1) at every cycle after reset. Consecutive counting steps change exactly one gray_out bit.
- Wrap rules:
  - wrap <= 1 on the edge where up=1 and bin_out == 2**WIDTH-1 (so the next value is 0).
  - wrap <= 1 on the edge where up=0 and bin_out == 0 (so the next value is 2**WIDTH-1).
  - Otherwise wrap <= 0.
  - wrap is registered and high for exactly one cycle per wrap step.
- Direction change mid-count: takes effect on the next enabled edge; no bubble cycle.
- Reset mid-count or mid-load: reset wins; outputs take the reset values on that edge; wrap = 0.
- Outputs are driven only from registers; no combinational input-to-output path.

Decomposition:
- Shared package gray_pkg holds:
  - bin2gray and gray2bin functions, parametrised by width.
  - The constant DEF_WIDTH = 3.
- One natural sub-module: gray_codec, purely combinational, instantiated twice:
  - bin->gray on next_bin.
  - gray->bin on load_gray.
- The top level holds the binary register, the next-value mux, the Gray register and the wrap logic.
- Each gray_codec instance can also be tested exhaustively on its own against the 3-bit truth table.

Test Plan:
- Reset then up-count, WIDTH=3, en=1, up=1 for 9 cycles:
  - gray_out sequence 000,001,011,010,110,111,101,100,000.
  - bin_out runs 0..7 then 0.
  - wrap high only in the cycle bin_out shows 0 after 7.
- Down-count from reset, up=0:
  - first step gives bin_out=7, gray_out=100, wrap=1 for one cycle.
  - then 6/101, 5/111.
- Load priority: load=1, load_gray=110, en=1, up=1 in the same cycle:
  - next cycle bin_out=100, gray_out=110, wrap=0.
  - the following enabled cycle gives bin_out=101, gray_out=111.
- Hold and direction switch:
  - en=0 for 3 cycles -> outputs frozen.
  - toggle up each cycle with en=1 -> count alternates 4,5,4,5.
  - gray_out differs by one bit every step.
- Mid-operation reset, RESET_VAL=5, WIDTH=4: assert rst_n=0 while counting at bin_out=12 -> next edge bin_out=0101, gray_out=0111, wrap=0.
- Exhaustive invariant, WIDTH=8: run 600 random en/up/load cycles -> gray_out == bin_out ^ (bin_out >> 1) every cycle; Hamming distance between consecutive counting outputs is 1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the gray counter slice.
// Helpers work on a full 32-bit word; narrower callers zero-extend and truncate.
package gray_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_UP,
        OP_DOWN,
        OP_LOAD
    } op_e;

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits keep the prefix XOR correct for any width.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int unsigned i = MAX_WIDTH - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and result bundle between a gray_counter and its user.
interface gray_counter_if
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;

    modport master (
        output en, up, load, load_gray,
        input  bin_out, gray_out, wrap
    );

    modport slave (
        input  en, up, load, load_gray,
        output bin_out, gray_out, wrap
    );

endinterface

// File: rtl/gray_codec.sv
// Combinational binary<->Gray converter; TO_GRAY selects the direction.
module gray_codec
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter bit          TO_GRAY = 1'b1
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    word_t w_ext;

    assign w_ext = MAX_WIDTH'(i_val);

    always_comb begin
        o_val = '0;
        if (TO_GRAY) begin
            o_val = WIDTH'(bin2gray(w_ext));
        end else begin
            o_val = WIDTH'(gray2bin(w_ext));
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray copy, parallel Gray load
// and a one-cycle wrap pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    op_e              w_op;
    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_wrap;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    always_comb begin
        w_op = OP_HOLD;
        if (bus.load) begin
            w_op = OP_LOAD;
        end else if (bus.en) begin
            w_op = bus.up ? OP_UP : OP_DOWN;
        end
    end

    gray_codec #(
        .WIDTH   (WIDTH),
        .TO_GRAY (1'b0)
    ) u_load_dec (
        .i_val (bus.load_gray),
        .o_val (w_load_bin)
    );

    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        case (w_op)
            OP_LOAD: w_next_bin = w_load_bin;
            OP_UP: begin
                w_next_bin  = r_bin + WIDTH'(1);
                w_next_wrap = (r_bin == '1);
            end
            OP_DOWN: begin
                w_next_bin  = r_bin - WIDTH'(1);
                w_next_wrap = (r_bin == '0);
            end
            default: w_next_bin = r_bin;
        endcase
    end

    // Gray is always re-encoded from the next binary value; on load this
    // round-trips back to load_gray exactly, so one register path serves all ops.
    gray_codec #(
        .WIDTH   (WIDTH),
        .TO_GRAY (1'b1)
    ) u_next_enc (
        .i_val (w_next_bin),
        .o_val (w_next_gray)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= RESET_VAL;
            r_gray <= RESET_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_wrap <= w_next_wrap;
        end
    end

    assign bus.bin_out  = r_bin;
    assign bus.gray_out = r_gray;
    assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// Directed checks of gray_counter at widths 3, 4 (non-zero reset) and 8.
module tb_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst3_n;
    logic rst4_n;
    logic rst8_n;

    gray_counter_if #(.WIDTH(3)) if3 ();
    gray_counter_if #(.WIDTH(4)) if4 ();
    gray_counter_if #(.WIDTH(8)) if8 ();

    gray_counter #(.WIDTH(3), .RESET_VAL(3'd0)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (if3.slave)
    );

    gray_counter #(.WIDTH(4), .RESET_VAL(4'd5)) u_dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .bus   (if4.slave)
    );

    gray_counter #(.WIDTH(8), .RESET_VAL(8'd0)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .bus   (if8.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [2:0] b, input logic [2:0] g, input logic w);
        check({tag, ".bin"},  32'(if3.bin_out),  32'(b));
        check({tag, ".gray"}, 32'(if3.gray_out), 32'(g));
        check({tag, ".wrap"}, 32'(if3.wrap),     32'(w));
    endtask

    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    logic [2:0] up_bin  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [2:0] up_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic       up_wrap [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [2:0] prev3;
    logic [7:0] m_bin;
    logic [7:0] exp_bin;
    logic [7:0] prev_gray8;
    logic [7:0] lg;
    logic       exp_wrap;
    logic       e, u, l;

    initial begin
        if3.en = 0; if3.up = 0; if3.load = 0; if3.load_gray = '0;
        if4.en = 0; if4.up = 0; if4.load = 0; if4.load_gray = '0;
        if8.en = 0; if8.up = 0; if8.load = 0; if8.load_gray = '0;
        rst3_n = 0; rst4_n = 0; rst8_n = 0;
        step();

        // Reset state, all instances
        chk3("rst3", 3'd0, 3'b000, 1'b0);
        check("rst4.bin",  32'(if4.bin_out),  32'd5);
        check("rst4.gray", 32'(if4.gray_out), 32'b0111);
        check("rst4.wrap", 32'(if4.wrap),     32'd0);
        check("rst8.bin",  32'(if8.bin_out),  32'd0);

        // Up-count through a full wrap
        rst3_n = 1; if3.en = 1; if3.up = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk3($sformatf("up%0d", k), up_bin[k], up_gray[k], up_wrap[k]);
        end

        // Down-count from reset
        rst3_n = 0; step();
        chk3("rst3b", 3'd0, 3'b000, 1'b0);
        rst3_n = 1; if3.up = 0;
        step(); chk3("dn0", 3'd7, 3'b100, 1'b1);
        step(); chk3("dn1", 3'd6, 3'b101, 1'b0);
        step(); chk3("dn2", 3'd5, 3'b111, 1'b0);

        // Load beats count
        if3.load = 1; if3.load_gray = 3'b110; if3.en = 1; if3.up = 1;
        step(); chk3("ld", 3'd4, 3'b110, 1'b0);
        if3.load = 0;
        step(); chk3("ld+1", 3'd5, 3'b111, 1'b0);

        // Hold
        if3.en = 0;
        for (int k = 0; k < 3; k++) begin
            step(); chk3($sformatf("hold%0d", k), 3'd5, 3'b111, 1'b0);
        end

        // Direction toggle each cycle
        if3.en = 1;
        for (int k = 0; k < 4; k++) begin
            prev3 = if3.gray_out;
            if3.up = k[0];
            step();
            if (k[0]) chk3($sformatf("tog%0d", k), 3'd5, 3'b111, 1'b0);
            else      chk3($sformatf("tog%0d", k), 3'd4, 3'b110, 1'b0);
            check($sformatf("tog%0d.ham", k), 32'($countones(if3.gray_out ^ prev3)), 32'd1);
        end
        if3.en = 0;

        // WIDTH=4, RESET_VAL=5: count to 12, then reset during a load
        rst4_n = 1; if4.en = 1; if4.up = 1;
        for (int k = 6; k <= 12; k++) begin
            step();
            check($sformatf("w4.up%0d", k), 32'(if4.bin_out), 32'(k));
        end
        check("w4.gray12", 32'(if4.gray_out), 32'b1010);
        rst4_n = 0; if4.load = 1; if4.load_gray = 4'b1111;
        step();
        check("w4.mrst.bin",  32'(if4.bin_out),  32'b0101);
        check("w4.mrst.gray", 32'(if4.gray_out), 32'b0111);
        check("w4.mrst.wrap", 32'(if4.wrap),     32'd0);
        if4.load = 0; if4.en = 0;

        // WIDTH=8 random en/up/load against a reference model
        rst8_n = 1;
        m_bin = 8'd0;
        for (int k = 0; k < 600; k++) begin
            e  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 15) == 0);
            lg = 8'($urandom_range(0, 255));
            if8.en = e; if8.up = u; if8.load = l; if8.load_gray = lg;
            prev_gray8 = m_bin ^ (m_bin >> 1);
            exp_wrap = 1'b0;
            if (l) begin
                exp_bin = ref_g2b(lg);
            end else if (e && u) begin
                exp_wrap = (m_bin == 8'hFF);
                exp_bin  = m_bin + 8'd1;
            end else if (e) begin
                exp_wrap = (m_bin == 8'h00);
                exp_bin  = m_bin - 8'd1;
            end else begin
                exp_bin = m_bin;
            end
            step();
            check($sformatf("r%0d.bin", k),  32'(if8.bin_out),  32'(exp_bin));
            check($sformatf("r%0d.gray", k), 32'(if8.gray_out), 32'(exp_bin ^ (exp_bin >> 1)));
            check($sformatf("r%0d.wrap", k), 32'(if8.wrap),     32'(exp_wrap));
            if (e && !l) begin
                check($sformatf("r%0d.ham", k), 32'($countones(if8.gray_out ^ prev_gray8)), 32'd1);
            end
            m_bin = exp_bin;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
